soc_io_reg: RTL and testbench
=============================

SOC_IO_REG -- requirements
Module: soc_io_reg

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 100_000_000: clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115_200: UART bit rate.
REQ-003 SHALL have port clk, input, 1 bit: clock; all logic on rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port io_wen, input, 1 bit: write strobe, one write per asserted cycle.
REQ-006 SHALL have port io_waddr, input, 32 bits: write byte address.
REQ-007 SHALL have port io_wdata, input, 32 bits: write data.
REQ-008 SHALL have port io_wstrb, input, 4 bits: byte enables; bit n covers wdata[8n+7:8n].
REQ-009 SHALL have port io_ren, input, 1 bit: read strobe.
REQ-010 SHALL have port io_raddr, input, 32 bits: read byte address.
REQ-011 SHALL have port io_rdata, output, 32 bits: registered read data.
REQ-012 SHALL have port led, output, 1 bit: LED drive.
REQ-013 SHALL have port gpio, output, 8 bits: general-purpose outputs.
REQ-014 SHALL have port uart_tx, output, 1 bit: UART serial output, idle high.

Function
REQ-015 SHALL decode the word index io_*addr[4:2] and ignore all other address bits and addr[1:0].
REQ-016 SHALL use this map: 0x00 LED (bit0, RW); 0x04 GPIO (bits7:0, RW); 0x08 UART_TX (bits7:0, WO, reads 0); 0x0C UART_STATUS (bit0 = tx_busy, RO); other offsets read 0 and ignore writes.
REQ-017 SHALL update LED/GPIO on the clock edge where io_wen=1 and io_wstrb[0]=1; io_wstrb[3:1] has no effect on any register.
REQ-018 SHALL capture a UART_TX write (io_wen, io_wstrb[0]) only when tx_busy=0; a write while busy is dropped without error.
REQ-019 SHALL register io_rdata on the edge where io_ren=1, so data is valid the cycle after io_ren; io_rdata holds its value while io_ren=0.
REQ-020 SHALL return the pre-write value when a read and write to the same register occur in the same cycle.
REQ-021 SHALL raise tx_busy on the edge accepting a UART_TX write and clear it at the end of the stop bit.
REQ-022 SHALL transmit 8N1 frames: start bit 0, data bits LSB first, one stop bit 1; each bit lasts CLKS_PER_BIT = CLOCK_FREQ/BAUD_RATE cycles (integer division).
REQ-023 SHALL drive the start bit on uart_tx beginning the cycle after the accepting edge.
REQ-024 SHALL drive uart_tx from a register.
REQ-025 SHALL keep tx_busy asserted for exactly 10*CLKS_PER_BIT cycles per frame.
REQ-026 SHALL accept a new UART_TX write in the first cycle tx_busy reads 0, giving back-to-back frames with no extra idle bit.
REQ-027 SHALL use a bit-timer counter wide enough for CLKS_PER_BIT-1 and a 4-bit bit index.

Reset
REQ-028 SHALL, while rst_n=0 at a clock edge, set led=0, gpio=0, uart_tx=1, io_rdata=0 and tx_busy=0, and clear UART counters.
REQ-029 SHALL abort any frame in progress at reset, forcing uart_tx high by the next edge.
REQ-030 SHALL ignore io_wen and io_ren while rst_n=0.

Structure
REQ-031 SHALL place register offsets (0x00/0x04/0x08/0x0C) and the tx_busy bit position in a shared package soc_io_pkg.
REQ-032 SHALL implement serialization in one sub-module soc_uart_tx (inputs clk, rst_n, valid, data[7:0]; outputs busy, tx), parameterized by CLOCK_FREQ and BAUD_RATE.
REQ-033 SHALL keep the register file, address decode and read mux in soc_io_reg.

Verification (CLOCK_FREQ=100_000_000, BAUD_RATE=115_200, CLKS_PER_BIT=868)
REQ-034 SHALL cover reset: after reset release -> led=0, gpio=0, uart_tx=1, read 0x0C -> 0x00000000 the next cycle.
REQ-035 SHALL cover LED/GPIO writes: write 0x04 data 0xFFFFFFA5 wstrb 0xF, then write 0x00 data 0x1 -> gpio=0xA5, led=1; reads return 0x000000A5 and 0x00000001 one cycle after io_ren.
REQ-036 SHALL cover strobe masking: write 0x04 data 0x3C wstrb 0x2 -> gpio unchanged.
REQ-037 SHALL cover a UART frame: write 0x08 data 0x55 -> uart_tx low for 868 cycles, then 1,0,1,0,1,0,1,0 at 868 cycles each, then high; read 0x0C=1 throughout 8680 cycles, then 0.
REQ-038 SHALL cover busy drop: write 0x08 data 0x41 then, mid-frame, 0x42 -> only 0x41 transmitted, line idle afterward.
REQ-039 SHALL cover same-cycle read/write: read and write 0x04 (data 0x77) in the same cycle -> io_rdata shows the old gpio value; gpio=0x77 after the edge.

Source files
------------

// File: rtl/soc_io_pkg.sv
// -----------------------------------------------------------------------------
// soc_io_pkg
// Shared definitions for the SoC I/O register block:
//   - byte offsets of the four registers (LED, GPIO, UART_TX, UART_STATUS)
//   - bit position of tx_busy inside UART_STATUS
//   - UART transmitter state encoding
//   - helper that extracts the decoded word index from a byte address
// No ports (package).
// -----------------------------------------------------------------------------
package soc_io_pkg;

   localparam logic [7:0] LED_OFFSET         = 8'h00;
   localparam logic [7:0] GPIO_OFFSET        = 8'h04;
   localparam logic [7:0] UART_TX_OFFSET     = 8'h08;
   localparam logic [7:0] UART_STATUS_OFFSET = 8'h0C;

   localparam int TX_BUSY_BIT = 0;

   // Only address bits [4:2] select a register; everything else aliases.
   function automatic logic [2:0] word_index(input logic [7:0] byte_offset);
      return byte_offset[4:2];
   endfunction

   typedef enum logic {
      TX_IDLE,
      TX_SEND
   } tx_state_e;

endpackage

// File: rtl/soc_uart_tx.sv
// -----------------------------------------------------------------------------
// soc_uart_tx
// 8N1 UART serializer. A byte offered on data with valid=1 is accepted only
// while busy=0; offers made while busy are ignored. The start bit appears on
// tx the cycle after the accepting edge, followed by data LSB first and one
// stop bit, each CLOCK_FREQ/BAUD_RATE cycles long. busy is high for exactly
// ten bit periods per frame.
//
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   synchronous active-low reset; aborts any frame, tx forced high
//   valid  in   request to send data
//   data   in   [7:0] byte to send
//   busy   out  frame in progress
//   tx     out  registered serial line, idle high
// -----------------------------------------------------------------------------
module soc_uart_tx
   import soc_io_pkg::*;
#(
   parameter int CLOCK_FREQ = 100_000_000,
   parameter int BAUD_RATE  = 115_200
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       valid,
   input  logic [7:0] data,
   output logic       busy,
   output logic       tx
);

   localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
   localparam int TIMER_W      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CLKS_PER_BIT - 1);
   // Bit index counts start(0), data(1..8), stop(9).
   localparam logic [3:0] LAST_BIT = 4'd9;

   tx_state_e          state_q, state_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic [3:0]         bit_idx_q, bit_idx_d;
   // Holds the bits still to be shifted out; the top bit is the stop bit and
   // ones are shifted in behind it so the line rests high.
   logic [8:0]         shreg_q, shreg_d;
   logic               tx_q, tx_d;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the values from before the edge, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= TX_IDLE;
         timer_q   <= '0;
         bit_idx_q <= '0;
         shreg_q   <= '1;
         tx_q      <= 1'b1;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         bit_idx_q <= bit_idx_d;
         shreg_q   <= shreg_d;
         tx_q      <= tx_d;
      end
   end

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path
      // leaves one unassigned and no latch is inferred.
      state_d   = state_q;
      timer_d   = timer_q;
      bit_idx_d = bit_idx_q;
      shreg_d   = shreg_q;
      tx_d      = tx_q;

      case (state_q)
         TX_IDLE: begin
            tx_d = 1'b1;
            if (valid) begin
               state_d   = TX_SEND;
               tx_d      = 1'b0;
               shreg_d   = {1'b1, data};
               timer_d   = '0;
               bit_idx_d = '0;
            end
         end

         TX_SEND: begin
            if (timer_q == TIMER_LAST) begin
               timer_d = '0;
               if (bit_idx_q == LAST_BIT) begin
                  // End of stop bit: line stays high, frame done.
                  state_d   = TX_IDLE;
                  tx_d      = 1'b1;
                  bit_idx_d = '0;
               end else begin
                  bit_idx_d = bit_idx_q + 4'd1;
                  tx_d      = shreg_q[0];
                  shreg_d   = {1'b1, shreg_q[8:1]};
               end
            end else begin
               timer_d = timer_q + TIMER_W'(1);
            end
         end

         default: begin
            state_d = TX_IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

   assign busy = (state_q == TX_SEND);
   assign tx   = tx_q;

endmodule

// File: rtl/soc_io_reg.sv
// -----------------------------------------------------------------------------
// soc_io_reg
// Memory-mapped I/O register block: LED, 8-bit GPIO, UART transmit data and
// UART status. Only address bits [4:2] are decoded. Reads are registered on
// the edge where io_ren=1 and hold otherwise; a read in the same cycle as a
// write returns the value from before the write. Only io_wstrb[0] matters.
//
// Map (byte offset):
//   0x00 LED         bit0      RW
//   0x04 GPIO        bits7:0   RW
//   0x08 UART_TX     bits7:0   WO (reads 0), dropped while tx_busy
//   0x0C UART_STATUS bit0      RO tx_busy
//   others read 0, writes ignored
//
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   synchronous active-low reset
//   io_wen    in   write strobe
//   io_waddr  in   [31:0] write byte address
//   io_wdata  in   [31:0] write data
//   io_wstrb  in   [3:0] byte enables
//   io_ren    in   read strobe
//   io_raddr  in   [31:0] read byte address
//   io_rdata  out  [31:0] registered read data
//   led       out  LED drive
//   gpio      out  [7:0] general-purpose outputs
//   uart_tx   out  UART serial line, idle high
// -----------------------------------------------------------------------------
module soc_io_reg
   import soc_io_pkg::*;
#(
   parameter int CLOCK_FREQ = 100_000_000,
   parameter int BAUD_RATE  = 115_200
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        io_wen,
   input  logic [31:0] io_waddr,
   input  logic [31:0] io_wdata,
   input  logic [3:0]  io_wstrb,
   input  logic        io_ren,
   input  logic [31:0] io_raddr,
   output logic [31:0] io_rdata,
   output logic        led,
   output logic [7:0]  gpio,
   output logic        uart_tx
);

   localparam logic [2:0] LED_IDX         = word_index(LED_OFFSET);
   localparam logic [2:0] GPIO_IDX        = word_index(GPIO_OFFSET);
   localparam logic [2:0] UART_TX_IDX     = word_index(UART_TX_OFFSET);
   localparam logic [2:0] UART_STATUS_IDX = word_index(UART_STATUS_OFFSET);

   logic        led_q;
   logic [7:0]  gpio_q;
   logic [31:0] rdata_q;
   logic [31:0] rd_word;
   logic [2:0]  wsel;
   logic [2:0]  rsel;
   logic        wr_low_byte;
   logic        tx_valid;
   logic        tx_busy;

   assign wsel        = io_waddr[4:2];
   assign rsel        = io_raddr[4:2];
   assign wr_low_byte = io_wen && io_wstrb[0];
   // The transmitter itself drops the offer when it is busy.
   assign tx_valid    = wr_low_byte && (wsel == UART_TX_IDX);

   soc_uart_tx #(
      .CLOCK_FREQ (CLOCK_FREQ),
      .BAUD_RATE  (BAUD_RATE)
   ) u_uart_tx (
      .clk   (clk),
      .rst_n (rst_n),
      .valid (tx_valid),
      .data  (io_wdata[7:0]),
      .busy  (tx_busy),
      .tx    (uart_tx)
   );

   always_comb begin
      rd_word = '0;
      case (rsel)
         LED_IDX:         rd_word[0]           = led_q;
         GPIO_IDX:        rd_word[7:0]         = gpio_q;
         UART_STATUS_IDX: rd_word[TX_BUSY_BIT] = tx_busy;
         default:         rd_word              = '0;
      endcase
   end

   // The read mux sees the registers before this edge's write lands, which
   // gives read-before-write ordering for same-cycle accesses.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         led_q   <= 1'b0;
         gpio_q  <= '0;
         rdata_q <= '0;
      end else begin
         if (wr_low_byte) begin
            if (wsel == LED_IDX) begin
               led_q <= io_wdata[0];
            end
            if (wsel == GPIO_IDX) begin
               gpio_q <= io_wdata[7:0];
            end
         end
         if (io_ren) begin
            rdata_q <= rd_word;
         end
      end
   end

   assign io_rdata = rdata_q;
   assign led      = led_q;
   assign gpio     = gpio_q;

   // Address and data bits outside the decoded range are intentionally unused.
   logic unused_bits;
   assign unused_bits = ^{io_waddr[31:5], io_waddr[1:0],
                          io_raddr[31:5], io_raddr[1:0],
                          io_wdata[31:8], io_wstrb[3:1]};

endmodule

// File: tb/tb_soc_io_reg.sv
// -----------------------------------------------------------------------------
// tb_soc_io_reg
// Directed bench for soc_io_reg. Read requests push their expected data into
// a queue; a read monitor pops and compares one cycle after each io_ren.
// UART bytes expected on the line are queued likewise and a serial monitor
// decodes frames from uart_tx and compares them.
// -----------------------------------------------------------------------------
module tb_soc_io_reg;

   localparam int CLOCK_FREQ = 100_000_000;
   localparam int BAUD_RATE  = 115_200;
   localparam int CPB        = 868;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        io_wen;
   logic [31:0] io_waddr;
   logic [31:0] io_wdata;
   logic [3:0]  io_wstrb;
   logic        io_ren;
   logic [31:0] io_raddr;
   logic [31:0] io_rdata;
   logic        led;
   logic [7:0]  gpio;
   logic        uart_tx;

   always #5 clk = ~clk;

   soc_io_reg #(
      .CLOCK_FREQ (CLOCK_FREQ),
      .BAUD_RATE  (BAUD_RATE)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .io_wen   (io_wen),
      .io_waddr (io_waddr),
      .io_wdata (io_wdata),
      .io_wstrb (io_wstrb),
      .io_ren   (io_ren),
      .io_raddr (io_raddr),
      .io_rdata (io_rdata),
      .led      (led),
      .gpio     (gpio),
      .uart_tx  (uart_tx)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] rd_q[$];
   logic [7:0]  uart_q[$];
   bit          uart_mon_en = 1'b1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One bus cycle: drive, let the edge take it, release 1 unit later.
   task automatic bus_cycle(input bit wen, input logic [31:0] waddr, input logic [31:0] wdata,
                            input logic [3:0] wstrb, input bit ren, input logic [31:0] raddr,
                            input logic [31:0] rexp);
      io_wen   = wen;
      io_waddr = waddr;
      io_wdata = wdata;
      io_wstrb = wstrb;
      io_ren   = ren;
      io_raddr = raddr;
      if (ren && rst_n) rd_q.push_back(rexp);
      @(posedge clk);
      #1;
      io_wen   = 1'b0;
      io_ren   = 1'b0;
      io_wstrb = 4'h0;
   endtask

   task automatic write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
      bus_cycle(1'b1, addr, data, strb, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic read(input logic [31:0] addr, input logic [31:0] exp);
      bus_cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, addr, exp);
   endtask

   // Return #1 after edge t-1, so the next bus cycle is taken at edge t.
   task automatic wait_edge(input int t);
      while (cyc < t - 1) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Read monitor: data is due on the edge after io_ren.
   initial begin
      bit issued;
      forever begin
         @(posedge clk);
         issued = (io_ren === 1'b1) && (rst_n === 1'b1);
         @(negedge clk);
         if (issued) begin
            if (rd_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL rdata: got 0x%08h with no expected value queued", io_rdata);
            end else begin
               check("rdata", io_rdata, rd_q.pop_front());
            end
         end
      end
   end

   // UART monitor: decode each frame, sampling mid-bit.
   initial begin
      logic [7:0] rx;
      forever begin
         @(negedge uart_tx);
         if (rst_n === 1'b1 && uart_mon_en) begin
            repeat (CPB / 2) @(negedge clk);
            check("uart start bit", {31'b0, uart_tx}, 32'h0);
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clk);
               rx[i] = uart_tx;
            end
            repeat (CPB) @(negedge clk);
            check("uart stop bit", {31'b0, uart_tx}, 32'h1);
            if (uart_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL uart byte: got 0x%02h with no frame expected", rx);
            end else begin
               check("uart byte", {24'b0, rx}, {24'b0, uart_q.pop_front()});
            end
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int e0;
      int e1;
      int n;

      rst_n    = 1'b0;
      io_wen   = 1'b0;
      io_waddr = 32'h0;
      io_wdata = 32'h0;
      io_wstrb = 4'h0;
      io_ren   = 1'b0;
      io_raddr = 32'h0;

      // Reset, with a write attempt that must be ignored.
      repeat (2) @(posedge clk);
      #1;
      write(32'h00, 32'h1, 4'hF);
      check("reset led", {31'b0, led}, 32'h0);
      check("reset gpio", {24'b0, gpio}, 32'h0);
      check("reset uart_tx", {31'b0, uart_tx}, 32'h1);
      check("reset rdata", io_rdata, 32'h0);

      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post-reset led", {31'b0, led}, 32'h0);
      check("post-reset gpio", {24'b0, gpio}, 32'h0);
      check("post-reset uart_tx", {31'b0, uart_tx}, 32'h1);
      read(32'h0C, 32'h0);

      // LED / GPIO writes and readback.
      write(32'h04, 32'hFFFF_FFA5, 4'hF);
      write(32'h00, 32'h1, 4'hF);
      check("gpio after write", {24'b0, gpio}, 32'hA5);
      check("led after write", {31'b0, led}, 32'h1);
      read(32'h04, 32'h0000_00A5);
      read(32'h00, 32'h0000_0001);
      repeat (3) @(posedge clk);
      #1;
      check("rdata hold", io_rdata, 32'h1);

      // Strobe masking and address aliasing.
      write(32'h04, 32'h3C, 4'h2);
      check("gpio strobe masked", {24'b0, gpio}, 32'hA5);
      write(32'hFFFF_FFE4, 32'h0000_015A, 4'h1);
      check("gpio aliased addr", {24'b0, gpio}, 32'h5A);
      write(32'h1C, 32'hFF, 4'hF);
      write(32'h10, 32'h0, 4'hF);
      check("gpio unmapped writes", {24'b0, gpio}, 32'h5A);
      check("led unmapped writes", {31'b0, led}, 32'h1);
      read(32'h14, 32'h0);
      read(32'h08, 32'h0);
      read(32'h0000_0107, 32'h0000_005A);

      // Same-cycle read and write of GPIO returns the old value.
      bus_cycle(1'b1, 32'h04, 32'h77, 4'hF, 1'b1, 32'h04, 32'h0000_005A);
      check("gpio after rw", {24'b0, gpio}, 32'h77);

      // UART frame 0x55 with start-bit timing and busy window.
      uart_q.push_back(8'h55);
      write(32'h08, 32'h55, 4'h1);
      e0 = cyc;
      check("start bit immediate", {31'b0, uart_tx}, 32'h0);
      @(negedge clk);
      n = 0;
      while (uart_tx === 1'b0 && n < 2000) begin
         n++;
         @(negedge clk);
      end
      check("start bit width", n, CPB);
      wait_edge(e0 + 4000);
      read(32'h0C, 32'h1);
      wait_edge(e0 + 10 * CPB);
      read(32'h0C, 32'h1);
      check("stop bit before idle", {31'b0, uart_tx}, 32'h1);

      // First cycle busy reads 0: status read and back-to-back write 0x41.
      uart_q.push_back(8'h41);
      bus_cycle(1'b1, 32'h08, 32'h41, 4'h1, 1'b1, 32'h0C, 32'h0);
      e1 = cyc;
      check("back-to-back start", {31'b0, uart_tx}, 32'h0);

      // A write mid-frame is dropped.
      wait_edge(e1 + 3000);
      write(32'h08, 32'h42, 4'h1);
      wait_edge(e1 + 10 * CPB + 10);
      read(32'h0C, 32'h0);
      check("idle after frame", {31'b0, uart_tx}, 32'h1);
      wait_edge(e1 + 13 * CPB + 100);
      check("idle later", {31'b0, uart_tx}, 32'h1);
      check("uart frames pending", uart_q.size(), 32'h0);

      // Reset aborts a frame in progress.
      read(32'h04, 32'h77);
      uart_mon_en = 1'b0;
      write(32'h08, 32'h00, 4'h1);
      e0 = cyc;
      wait_edge(e0 + 1000);
      check("frame in progress", {31'b0, uart_tx}, 32'h0);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("abort uart_tx", {31'b0, uart_tx}, 32'h1);
      check("abort gpio", {24'b0, gpio}, 32'h0);
      check("abort led", {31'b0, led}, 32'h0);
      check("abort rdata", io_rdata, 32'h0);
      rst_n = 1'b1;
      read(32'h0C, 32'h0);
      repeat (5) @(posedge clk);
      #1;
      check("uart idle after abort", {31'b0, uart_tx}, 32'h1);
      check("reads pending", rd_q.size(), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
